mux2_rr_arbiter: RTL
====================

// Module: mux2_rr_arbiter
// PURPOSE
//  Two-channel round-robin arbiter with a one-entry registered output stage.
//  Accepts WIDTH-bit words on two valid/ready input channels d0/d1.
//  Grants one channel per transfer and emits the word with its source select.
//  Sits directly upstream of the 2:1 data mux stage and generates the sel it consumes.
// PARAMETERS
//  WIDTH   2   data width of d0, d1 and out
// PORTS
//  clk        in   1      single clock, all state updates on posedge
//  rst_n      in   1      asynchronous, active-low reset
//  d0         in   WIDTH  channel 0 data
//  d0_valid   in   1      channel 0 word present
//  d0_ready   out  1      channel 0 word accepted this cycle
//  d1         in   WIDTH  channel 1 data
//  d1_valid   in   1      channel 1 word present
//  d1_ready   out  1      channel 1 word accepted this cycle
//  out        out  WIDTH  registered selected word
//  out_valid  out  1      out holds an unconsumed word
//  out_ready  in   1      downstream accepts out this cycle
//  sel        out  1      source of out: 0 = d0, 1 = d1; feeds the mux stage
// BEHAVIOUR
//  - Reset (async assert, sync release): out=0, out_valid=0, sel=0, last_grant=1.
//    The first contested grant therefore goes to d0.
//  - FSM states:
//    - EMPTY (out_valid=0): any d*_valid -> LOAD, move to FULL.
//    - FULL (out_valid=1):
//      - out_ready=0: hold; out and sel stable.
//      - out_ready=1 with a request: reload (LOAD) the same cycle, stay FULL.
//      - out_ready=1 without a request: move to EMPTY.
//  - can_load = !out_valid | out_ready.
//  - Arbitration (combinational, from valids and last_grant):
//    - Only one channel valid: that channel wins.
//    - Both valid: winner = !last_grant.
//  - dN_ready = can_load & (winner==N). Never both high; ready may depend on valid.
//  - LOAD: out<=winner data, sel<=winner, last_grant<=winner, out_valid<=1.
//  - Latency: accepted input appears on out the next cycle. Throughput 1 word/cycle.
//  - last_grant changes only on an accepted transfer. A losing channel is never
//    starved: it wins the next contested transfer.
//  - Mid-transfer reset drops any held word; inputs are not acknowledged.
//  - Inputs must hold data stable while valid & !ready (standard valid/ready rule).
// CONFIGURATION
//  MUX2_RR_ARBITER_STATS_EN
//   - Defined: adds outputs gnt_cnt0, gnt_cnt1 (out, 8 bits).
//     - Each counts accepted transfers per channel and saturates at 8'hFF.
//     - Both clear to 0 on reset.
//   - Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  Shared package mux_pkg:
//   - localparam SEL_D0=1'b0, SEL_D1=1'b1.
//   - Default data width constant MUX_W=2.
//  Sub-module rr_grant2:
//   - Purely combinational: inputs req[1:0], last, en; output gnt[1:0].
//   - Reused for any future two-requester arbitration.
//  Top level holds the output register, last_grant flop and optional counters.
// TESTING
//  1. Reset: rst_n=0 mid-stream -> out=0, out_valid=0, sel=0 immediately, no clk needed.
//  2. Single channel: d0=2'b10 valid, out_ready=1 -> d0_ready=1.
//     Next cycle: out=2'b10, sel=0, out_valid=1.
//  3. Contention: both valid for 4 cycles, out_ready=1, d0=2'b01, d1=2'b11
//     -> sel sequence 0,1,0,1; out 01,11,01,11.
//  4. Backpressure: out_valid=1, out_ready=0 for 3 cycles -> out/sel unchanged,
//     d0_ready=d1_ready=0. Release -> next word loads in the same cycle.
//  5. Drain: last word consumed with no valids -> out_valid=0 next cycle.
//     A new d1 request then loads with 1-cycle latency.
//  6. STATS_EN: 300 d0 transfers -> gnt_cnt0=8'hFF, gnt_cnt1=0. Reset clears both.

Source files
------------

// File: rtl/mux2_rr_arbiter_pkg.sv
// Shared definitions for the two-channel round-robin arbiter slice.
package mux_pkg;

  localparam logic SEL_D0 = 1'b0;
  localparam logic SEL_D1 = 1'b1;
  localparam int   MUX_W  = 2;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/mux2_rr_arbiter_if.sv
// Valid/ready bundle for mux2_rr_arbiter: two input channels, one registered output.
interface mux2_rr_arbiter_if
  import mux_pkg::*;
#(
  parameter int WIDTH = MUX_W
);

  logic [WIDTH-1:0] d0;
  logic             d0_valid;
  logic             d0_ready;
  logic [WIDTH-1:0] d1;
  logic             d1_valid;
  logic             d1_ready;
  logic [WIDTH-1:0] out;
  logic             out_valid;
  logic             out_ready;
  logic             sel;

  // master: sources d0/d1 and consumes out
  modport master (
    output d0, d0_valid, d1, d1_valid, out_ready,
    input  d0_ready, d1_ready, out, out_valid, sel
  );

  modport slave (
    input  d0, d0_valid, d1, d1_valid, out_ready,
    output d0_ready, d1_ready, out, out_valid, sel
  );

endinterface

// File: rtl/mux2_rr_arbiter_grant.sv
// rr_grant2: combinational two-requester round-robin grant; last = previous winner.
module rr_grant2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       en,
  output logic [1:0] gnt
);

  // A contested request goes to the channel that did not win last time.
  always_comb begin
    gnt    = '0;
    gnt[0] = en & req[0] & (~req[1] | last);
    gnt[1] = en & req[1] & (~req[0] | ~last);
  end

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Two-channel round-robin arbiter with a one-entry registered output stage.
// Optional MUX2_RR_ARBITER_STATS_EN adds saturating per-channel grant counters.
module mux2_rr_arbiter
  import mux_pkg::*;
#(
  parameter int WIDTH = MUX_W
) (
  input  logic        clk,
  input  logic        rst_n,
  mux2_rr_arbiter_if.slave bus
`ifdef MUX2_RR_ARBITER_STATS_EN
  ,
  output logic [7:0]  gnt_cnt0,
  output logic [7:0]  gnt_cnt1
`endif
);

  state_t     state;
  state_t     state_nx;
  logic       last_grant;
  logic [1:0] gnt;
  logic       can_load;
  logic       load;
  logic       winner;

  // Gated by rst_n so no input is acknowledged while reset is asserted.
  always_comb begin
    can_load = rst_n & ((state == EMPTY) | bus.out_ready);
  end

  rr_grant2 u_grant (
    .req  ({bus.d1_valid, bus.d0_valid}),
    .last (last_grant),
    .en   (can_load),
    .gnt  (gnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      EMPTY:   if (load) state_nx = FULL;
      FULL:    if (bus.out_ready && !load) state_nx = EMPTY;
      default: state_nx = EMPTY;
    endcase
  end

  always_comb begin
    load          = |gnt;
    winner        = gnt[1] ? SEL_D1 : SEL_D0;
    bus.d0_ready  = gnt[0];
    bus.d1_ready  = gnt[1];
    bus.out_valid = (state == FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out    <= '0;
      bus.sel    <= SEL_D0;
      last_grant <= SEL_D1;
    end else if (load) begin
      bus.out    <= (winner == SEL_D1) ? bus.d1 : bus.d0;
      bus.sel    <= winner;
      last_grant <= winner;
    end
  end

`ifdef MUX2_RR_ARBITER_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_cnt0 <= '0;
      gnt_cnt1 <= '0;
    end else begin
      if (gnt[0] && gnt_cnt0 != '1) gnt_cnt0 <= gnt_cnt0 + 8'd1;
      if (gnt[1] && gnt_cnt1 != '1) gnt_cnt1 <= gnt_cnt1 + 8'd1;
    end
  end
`endif

endmodule
